// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_wr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } state_e;

    // Active-low pin levels: nT asserts, nF deasserts
    localparam logic nT = 1'b0;
    localparam logic nF = 1'b1;

    localparam int DEF_NREQ     = 2;
    localparam int DEF_MAXBURST = 4;
    localparam int DEF_WRLEN    = 1;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO-pin bundle between sources and the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic [7:0]        port;
    logic              n_wr;
    logic              n_txe;
    logic              busy;

    // master: producers plus FIFO status side; slave: the arbiter
    modport master (output req, data, n_txe, input grant, ack, port, n_wr, busy);
    modport slave  (input req, data, n_txe, output grant, ack, port, n_wr, busy);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker starting after last owner
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] oh_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int j;

    // Scan farthest-to-nearest so the nearest requester after last_i wins
    always_comb begin
        oh_o  = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last_i) + k) % NREQ;
            if (req_i[j]) begin
                oh_o    = '0;
                oh_o[j] = 1'b1;
                idx_o   = IW'(j);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FT245-style write sequencer; optional FIFO_WR_ARBITER_BYTECNT_EN byte counter
module fifo_wr_arbiter
    import fifo_wr_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int MAXBURST = DEF_MAXBURST,
    parameter int WRLEN    = DEF_WRLEN
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
`ifdef FIFO_WR_ARBITER_BYTECNT_EN
    ,
    output logic [15:0]       bytecnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic [7:0]      port_q;
    logic            n_wr_q;
    logic [IW-1:0]   sel_q;
    logic [IW-1:0]   last_q;
    logic [BW-1:0]   burst_q;
    logic [3:0]      wcnt_q;

    logic [NREQ-1:0] pick_oh_d;
    logic [IW-1:0]   pick_idx_d;
    logic            pick_any_d;
    logic [7:0]      pick_byte_d;
    logic [7:0]      sel_byte_d;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .oh_o   (pick_oh_d),
        .idx_o  (pick_idx_d),
        .any_o  (pick_any_d)
    );

    assign pick_byte_d = bus.data[8*int'(pick_idx_d) +: 8];
    assign sel_byte_d  = bus.data[8*int'(sel_q) +: 8];

    // Write sequencer: pick, setup, strobe for WRLEN cycles, recover then burst or rotate
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            port_q  <= 8'h00;
            n_wr_q  <= nF;
            sel_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            burst_q <= '0;
            wcnt_q  <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.n_txe == nT && pick_any_d) begin
                        grant_q <= pick_oh_d;
                        sel_q   <= pick_idx_d;
                        port_q  <= pick_byte_d;
                        burst_q <= BW'(1);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    n_wr_q  <= nT;
                    wcnt_q  <= 4'd1;
                    if (WRLEN == 1) ack_q <= grant_q;
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (wcnt_q >= 4'(WRLEN)) begin
                        n_wr_q  <= nF;
                        state_q <= RECOVER;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                        if (wcnt_q + 4'd1 == 4'(WRLEN)) ack_q <= grant_q;
                    end
                end
                RECOVER: begin
                    if (bus.req[sel_q] && burst_q < BW'(MAXBURST) && bus.n_txe == nT) begin
                        port_q  <= sel_byte_d;
                        burst_q <= burst_q + BW'(1);
                        state_q <= SETUP;
                    end else begin
                        last_q  <= sel_q;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.port  = port_q;
    assign bus.n_wr  = n_wr_q;
    assign bus.busy  = (state_q != IDLE);

`ifdef FIFO_WR_ARBITER_BYTECNT_EN
    logic [15:0] bytecnt_q;

    // Count consumed bytes; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            bytecnt_q <= 16'h0000;
        end else if (|ack_q) begin
            bytecnt_q <= bytecnt_q + 16'd1;
        end
    end

    assign bytecnt = bytecnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fifo_wr_arbiter_if #(.NREQ(2)) bus ();

`ifdef FIFO_WR_ARBITER_BYTECNT_EN
    logic [15:0] bytecnt;
`endif

    fifo_wr_arbiter #(
        .NREQ     (2),
        .MAXBURST (4),
        .WRLEN    (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef FIFO_WR_ARBITER_BYTECNT_EN
        ,
        .bytecnt (bytecnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int got;
        int bad;
        int cyc;
        int ack_cyc[5];
        logic [1:0] exp_oh;
        logic [7:0] exp_byte;

        n_checks = 0;
        n_pass   = 0;
        rst       = 1'b1;
        bus.req   = 2'b11;
        bus.data  = {8'h78, 8'h61};
        bus.n_txe = 1'b0;

        // Reset state while requests are pending
        tick();
        tick();
        check("rst_n_wr",  32'(bus.n_wr),  32'h1);
        check("rst_port",  32'(bus.port),  32'h00);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_ack",   32'(bus.ack),   32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);

        // Single byte from source 0: cycle-exact latency
        rst     = 1'b0;
        bus.req = 2'b01;
        tick();
        check("one_grant", 32'(bus.grant), 32'h1);
        check("one_port",  32'(bus.port),  32'h61);
        check("one_setup_nwr", 32'(bus.n_wr), 32'h1);
        check("one_setup_ack", 32'(bus.ack),  32'h0);
        tick();
        check("one_strobe_nwr", 32'(bus.n_wr), 32'h0);
        check("one_strobe_ack", 32'(bus.ack),  32'h1);
        bus.req = 2'b00;
        tick();
        check("one_rec_nwr",  32'(bus.n_wr), 32'h1);
        check("one_rec_ack",  32'(bus.ack),  32'h0);
        check("one_rec_busy", 32'(bus.busy), 32'h1);
        tick();
        check("one_idle_busy",  32'(bus.busy),  32'h0);
        check("one_idle_grant", 32'(bus.grant), 32'h0);

        // Both sources held: bursts of 4 alternate a, x
        bus.req = 2'b11;
        do_reset();
        got = 0;
        cyc = 0;
        while (got < 16 && cyc < 300) begin
            tick();
            cyc++;
            if (bus.ack != 2'b00) begin
                exp_oh   = ((got / 4) % 2 == 0) ? 2'b01 : 2'b10;
                exp_byte = ((got / 4) % 2 == 0) ? 8'h61 : 8'h78;
                check("burst_ack",  32'(bus.ack),  32'(exp_oh));
                check("burst_port", 32'(bus.port), 32'(exp_byte));
                check("burst_nwr",  32'(bus.n_wr), 32'h0);
                got++;
            end
        end
        check("burst_count", 32'(got), 32'd16);

        // n_txe high blocks any start
        bus.req   = 2'b01;
        bus.n_txe = 1'b1;
        do_reset();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.n_wr == 1'b0 || bus.busy == 1'b1) bad++;
        end
        check("txe_block", 32'(bad), 32'd0);
        bus.n_txe = 1'b0;
        tick();
        tick();
        check("txe_start_nwr", 32'(bus.n_wr), 32'h0);
        bus.n_txe = 1'b1;
        tick();
        check("txe_rec_nwr", 32'(bus.n_wr), 32'h1);
        tick();
        check("txe_stop_busy", 32'(bus.busy), 32'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.n_wr == 1'b0 || bus.busy == 1'b1) bad++;
        end
        check("txe_no_more", 32'(bad), 32'd0);

        // Reset in the middle of a strobe
        bus.n_txe = 1'b0;
        bus.req   = 2'b10;
        do_reset();
        tick();
        check("mid_grant", 32'(bus.grant), 32'h2);
        tick();
        check("mid_strobe", 32'(bus.n_wr), 32'h0);
        rst = 1'b1;
        tick();
        check("mid_rst_nwr",   32'(bus.n_wr),  32'h1);
        check("mid_rst_ack",   32'(bus.ack),   32'h0);
        check("mid_rst_busy",  32'(bus.busy),  32'h0);
        check("mid_rst_grant", 32'(bus.grant), 32'h0);
        rst     = 1'b0;
        bus.req = 2'b11;
        tick();
        check("mid_restart", 32'(bus.grant), 32'h1);

        // Lone requester: MAXBURST rotation costs one idle cycle
        bus.req = 2'b01;
        do_reset();
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 100) begin
            tick();
            cyc++;
            if (bus.ack != 2'b00) begin
                ack_cyc[got] = cyc;
                got++;
            end
        end
        check("lone_count", 32'(got), 32'd5);
        if (got == 5) begin
            check("lone_gap_in",  32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
            check("lone_gap_rot", 32'(ack_cyc[4] - ack_cyc[3]), 32'd4);
        end

`ifdef FIFO_WR_ARBITER_BYTECNT_EN
        bus.req = 2'b11;
        do_reset();
        check("bcnt_rst", 32'(bytecnt), 32'd0);
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (bus.ack != 2'b00) got++;
        end
        tick();
        check("bcnt_ten", 32'(bytecnt), 32'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
